// File: rtl/apb_router.sv
// APB router: takes one request at a time on an en/ready handshake, runs the
// APB SETUP/ACCESS sequence on the selected slave, and reports rdata/err.
module apb_router #(
    parameter int NUM_SLV = 6,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 3,
    parameter int TMO_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      wr_in,
    input  logic [SEL_W-1:0]          sel_port,
    input  logic [ADDR_W-1:0]         addr_in,
    input  logic [DATA_W-1:0]         data_in,
    output logic                      ready,
    output logic [DATA_W-1:0]         rdata,
    output logic                      err,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr,
    output logic [1:0]                state_o
);

    // Handshake: the requester raises en with its request fields; they are
    // captured on the first edge in IDLE. ready pulses for exactly one cycle at
    // completion, and no new request is accepted until en has been seen low.

    localparam int                 CNT_W     = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0]   WAIT_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic [SEL_W:0]     NSLV      = (SEL_W + 1)'(NUM_SLV);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     wait_q, wait_d;
    logic                 ready_q, ready_d;
    logic                 err_q, err_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;
    logic [NUM_SLV-1:0]   psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]    paddr_q, paddr_d;
    logic [DATA_W-1:0]    pwdata_q, pwdata_d;

    logic                 sel_valid;
    logic [NUM_SLV-1:0]   psel_dec;
    logic                 sel_ready;
    logic                 sel_err;
    logic [DATA_W-1:0]    sel_rdata;

    assign sel_valid = {1'b0, sel_port} < NSLV;

    always_comb begin
        psel_dec = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            psel_dec[i] = ({1'b0, sel_port} == (SEL_W + 1)'(i));
        end
    end

    // The held one-hot psel masks the slave responses, so unselected slaves never leak in.
    assign sel_ready = |(pready & psel_q);
    assign sel_err   = |(pslverr & psel_q);

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (psel_q[i]) begin
                sel_rdata = sel_rdata | prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ready_d   = 1'b0;
        err_d     = err_q;
        rdata_d   = rdata_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;

        case (state_q)
            IDLE: begin
                if (en) begin
                    pwrite_d  = wr_in;
                    paddr_d   = addr_in;
                    pwdata_d  = data_in;
                    penable_d = 1'b0;
                    if (sel_valid) begin
                        psel_d  = psel_dec;
                        state_d = SETUP;
                    end else begin
                        psel_d  = '0;
                        ready_d = 1'b1;
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = DONE;
                    end
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                wait_d    = '0;
                state_d   = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = sel_err;
                    rdata_d   = pwrite_q ? '0 : sel_rdata;
                    state_d   = DONE;
                end else if (wait_q == WAIT_LAST) begin
                    // This edge is the TMO_CYC-th ACCESS cycle without pready.
                    psel_d    = '0;
                    penable_d = 1'b0;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    rdata_d   = '0;
                    state_d   = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: begin
                if (!en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
        end
    end

    assign ready   = ready_q;
    assign err     = err_q;
    assign rdata   = rdata_q;
    assign psel    = psel_q;
    assign penable = penable_q;
    assign pwrite  = pwrite_q;
    assign paddr   = paddr_q;
    assign pwdata  = pwdata_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_apb_router.sv
// Bench for apb_router: directed scenarios plus randomized transfers checked
// against a transfer-level model of latency, err and rdata.
module tb_apb_router;

    localparam int NUM_SLV = 6;
    localparam int ADDR_W  = 12;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 3;
    localparam int TMO_CYC = 16;
    localparam int W       = DATA_W + 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic                      wr_in;
    logic [SEL_W-1:0]          sel_port;
    logic [ADDR_W-1:0]         addr_in;
    logic [DATA_W-1:0]         data_in;
    logic                      ready;
    logic [DATA_W-1:0]         rdata;
    logic                      err;
    logic [NUM_SLV-1:0]        psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic [NUM_SLV*DATA_W-1:0] prdata;
    logic [NUM_SLV-1:0]        pready;
    logic [NUM_SLV-1:0]        pslverr;
    logic [1:0]                state_o;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]      exp_q[$];
    logic [DATA_W-1:0] last_rdata;
    logic              last_err;

    apb_router #(
        .NUM_SLV(NUM_SLV), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .SEL_W(SEL_W), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .wr_in(wr_in), .sel_port(sel_port),
        .addr_in(addr_in), .data_in(data_in), .ready(ready), .rdata(rdata),
        .err(err), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Every task starts and ends just after a falling edge.
    task automatic do_transfer(input logic wr, input int sel, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input int waits,
                               input logic slverr, input logic [DATA_W-1:0] rd_val,
                               input bit hold_en, input bit drop_early, input string name);
        logic [NUM_SLV-1:0] exp_psel;
        logic [DATA_W-1:0]  exp_r;
        logic               exp_e;
        logic [W-1:0]       exp_v;
        int                 exp_lat;
        int                 n;
        bit                 seen;
        bit                 valid;

        valid    = (sel < NUM_SLV);
        exp_psel = valid ? (NUM_SLV'(1) << sel) : '0;
        if (!valid) begin
            exp_lat = 0; exp_e = 1'b1; exp_r = '0;
        end else if (waits < TMO_CYC) begin
            exp_lat = waits + 1; exp_e = slverr; exp_r = wr ? '0 : rd_val;
        end else begin
            exp_lat = TMO_CYC; exp_e = 1'b1; exp_r = '0;
        end
        exp_q.push_back({exp_e, exp_r});

        en = 1'b1; wr_in = wr; sel_port = SEL_W'(sel); addr_in = addr; data_in = data;
        pready = '0; pslverr = '0;
        @(posedge clk); @(negedge clk);
        if (drop_early) en = 1'b0;
        wr_in = 1'($urandom); sel_port = SEL_W'($urandom); addr_in = ADDR_W'($urandom);
        data_in = $urandom;
        pready = NUM_SLV'($urandom);
        seen = 1'b0;

        if (!valid) begin
            seen = ready;
            checks++;
            if (ready !== 1'b1 || psel !== '0 || penable !== 1'b0) begin
                errors++;
                $display("FAIL %s badport: ready=%b psel=%b penable=%b, expected ready=1 psel=0 penable=0",
                         name, ready, psel, penable);
            end
        end else begin
            checks++;
            if (psel !== exp_psel || penable !== 1'b0 || ready !== 1'b0) begin
                errors++;
                $display("FAIL %s setup: psel=%b penable=%b ready=%b, expected psel=%b penable=0 ready=0",
                         name, psel, penable, ready, exp_psel);
            end
            checks++;
            if (rdata !== last_rdata || err !== last_err) begin
                errors++;
                $display("FAIL %s status_hold: rdata=%h err=%b, expected rdata=%h err=%b",
                         name, rdata, err, last_rdata, last_err);
            end
            @(posedge clk); @(negedge clk);
            checks++;
            if (psel !== exp_psel || penable !== 1'b1 || ready !== 1'b0) begin
                errors++;
                $display("FAIL %s enable: psel=%b penable=%b ready=%b, expected psel=%b penable=1 ready=0",
                         name, psel, penable, ready, exp_psel);
            end
            n = 0;
            while (!seen && n < TMO_CYC + 4) begin
                pready  = NUM_SLV'($urandom);
                pready[sel] = (n == waits);
                pslverr = NUM_SLV'($urandom);
                pslverr[sel] = slverr;
                for (int i = 0; i < NUM_SLV; i++) prdata[i*DATA_W +: DATA_W] = $urandom;
                prdata[sel*DATA_W +: DATA_W] = rd_val;
                @(posedge clk); @(negedge clk);
                n++;
                if (ready === 1'b1) begin
                    seen = 1'b1;
                end else begin
                    checks++;
                    if (penable !== 1'b1 || psel !== exp_psel) begin
                        errors++;
                        $display("FAIL %s access_hold: psel=%b penable=%b at cycle %0d, expected psel=%b penable=1",
                                 name, psel, penable, n, exp_psel);
                    end
                end
            end
            pready = '0;
            checks++;
            if (!seen || n != exp_lat) begin
                errors++;
                $display("FAIL %s latency: ready after %0d access cycles (seen=%0d), expected %0d",
                         name, n, seen, exp_lat);
            end
            checks++;
            if (psel !== '0 || penable !== 1'b0) begin
                errors++;
                $display("FAIL %s release: psel=%b penable=%b, expected psel=0 penable=0",
                         name, psel, penable);
            end
        end

        exp_v = exp_q.pop_front();
        checks++;
        if ({err, rdata} !== exp_v) begin
            errors++;
            $display("FAIL %s result: err=%b rdata=%h, expected err=%b rdata=%h",
                     name, err, rdata, exp_v[DATA_W], exp_v[DATA_W-1:0]);
        end
        last_err   = exp_v[DATA_W];
        last_rdata = exp_v[DATA_W-1:0];

        if (!seen) begin
            en = 1'b0; rst = 1'b1;
            @(posedge clk); @(negedge clk);
            rst = 1'b0; last_err = 1'b0; last_rdata = '0;
            return;
        end

        if (hold_en && !drop_early) begin
            repeat (3) begin
                @(posedge clk); @(negedge clk);
                checks++;
                if (ready !== 1'b0 || psel !== '0 || penable !== 1'b0) begin
                    errors++;
                    $display("FAIL %s en_held: ready=%b psel=%b penable=%b, expected all 0",
                             name, ready, psel, penable);
                end
            end
        end
        en = 1'b0;
        @(posedge clk); @(negedge clk);
        checks++;
        if (ready !== 1'b0 || rdata !== last_rdata || err !== last_err ||
            pwrite !== wr || paddr !== addr || pwdata !== data) begin
            errors++;
            $display("FAIL %s after: ready=%b rdata=%h err=%b pwrite=%b paddr=%h pwdata=%h, expected ready=0 rdata=%h err=%b pwrite=%b paddr=%h pwdata=%h",
                     name, ready, rdata, err, pwrite, paddr, pwdata, last_rdata, last_err, wr, addr, data);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; wr_in = 1'b0; sel_port = '0; addr_in = '0; data_in = '0;
        prdata = '0; pready = '0; pslverr = '0;
        last_rdata = '0; last_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (ready !== 1'b0 || err !== 1'b0 || rdata !== '0 || psel !== '0 || penable !== 1'b0 ||
            pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0) begin
            errors++;
            $display("FAIL reset: ready=%b err=%b rdata=%h psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, expected all 0",
                     ready, err, rdata, psel, penable, pwrite, paddr, pwdata);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        do_transfer(1'b1, 2, 12'h0A4, 32'hDEADBEEF, 0, 1'b0, 32'h0BADF00D, 1'b1, 1'b0, "write_sel2");
        do_transfer(1'b0, 5, 12'h100, 32'h0, 4, 1'b0, 32'h12345678, 1'b0, 1'b1, "read_wait_sel5");
        do_transfer(1'b0, 0, 12'h010, 32'h0, 0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0, "slverr_sel0");
        do_transfer(1'b0, 1, 12'h020, 32'h0, 1000, 1'b0, 32'h11111111, 1'b1, 1'b0, "timeout_sel1");
        do_transfer(1'b0, 3, 12'h030, 32'h0, TMO_CYC - 1, 1'b0, 32'h5A5A5A5A, 1'b0, 1'b0, "last_wait_sel3");
        do_transfer(1'b1, 4, 12'h040, 32'h77, TMO_CYC, 1'b0, 32'h22222222, 1'b0, 1'b0, "just_timeout_sel4");
        do_transfer(1'b1, 7, 12'h050, 32'h99, 0, 1'b0, 32'h0, 1'b1, 1'b0, "badport_sel7");
        do_transfer(1'b0, 6, 12'h060, 32'h0, 0, 1'b0, 32'h0, 1'b0, 1'b0, "badport_sel6");
    endtask

    task automatic test_reset_mid_access();
        en = 1'b1; wr_in = 1'b0; sel_port = 3'd4; addr_in = 12'h3C0; data_in = 32'h0; pready = '0;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        checks++;
        if (penable !== 1'b1 || psel !== 6'b010000) begin
            errors++;
            $display("FAIL rst_mid pre: penable=%b psel=%b, expected penable=1 psel=010000", penable, psel);
        end
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        checks++;
        if (ready !== 1'b0 || err !== 1'b0 || rdata !== '0 || psel !== '0 || penable !== 1'b0 ||
            pwrite !== 1'b0 || paddr !== '0 || pwdata !== '0) begin
            errors++;
            $display("FAIL rst_mid outputs: ready=%b err=%b rdata=%h psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h, expected all 0",
                     ready, err, rdata, psel, penable, pwrite, paddr, pwdata);
        end
        last_rdata = '0; last_err = 1'b0;
        do_transfer(1'b0, 3, 12'h3C4, 32'h0, 1, 1'b0, 32'hA5A51234, 1'b0, 1'b0, "after_rst_mid");
    endtask

    task automatic test_random();
        int sel;
        int waits;
        for (int k = 0; k < 30; k++) begin
            sel = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            waits = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO_CYC - 2, TMO_CYC + 1)
                                                : $urandom_range(0, 5);
            do_transfer(1'($urandom), sel, ADDR_W'($urandom), $urandom, waits,
                        1'($urandom_range(0, 3) == 0), $urandom,
                        1'($urandom), 1'($urandom_range(0, 3) == 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
